irq_aggregator: RTL and testbench

Avalon-MM interrupt aggregator that sits directly downstream of the interval timer's `irq` and the other peripheral interrupt lines. It synchronises up to 16 sources and captures each one as level- or edge-triggered into a pending register. It applies a per-source enable mask and drives one registered interrupt to the Nios CPU. Software reads the lowest-numbered active source, then acknowledges it by ID or by write-1-to-clear.

---
 rtl/irq_aggregator.sv | 128 ++++++++++++
 tb/tb_irq_aggregator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronises N_SRC lines, captures them as level or
// rising-edge events into a pending register, masks them and drives one registered irq.
module irq_aggregator #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [2:0]       address,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0] r_sync_d;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_edge;
  logic [15:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic [N_SRC-1:0] w_sync;
  logic [N_SRC-1:0] w_wdata;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_force;
  logic [N_SRC-1:0] w_eoi;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic [4:0]       w_active;
  logic [15:0]      w_rd;

  // Returns {valid, id} of the lowest set bit; scanning downwards lets the lowest index win.
  function automatic logic [4:0] lowest_active(input logic [N_SRC-1:0] v);
    logic [4:0] res;
    res = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

  assign w_wr     = chipselect & ~write_n;
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_wdata  = writedata[N_SRC-1:0];
  assign w_w1c    = (w_wr && address == 3'd1) ? w_wdata : '0;
  assign w_force  = (w_wr && address == 3'd5) ? w_wdata : '0;
  assign w_set    = (w_sync & ~w_sync_d_masked()) | w_force;
  assign w_clr    = w_w1c | w_eoi;
  assign w_active = lowest_active(r_pending & r_enable);

  // Edge-mode sources only see the rising transition; level-mode sources see the raw level.
  function automatic logic [N_SRC-1:0] w_sync_d_masked();
    return r_sync_d & r_edge;
  endfunction

  // EOI decode: an ID at or above N_SRC matches no bit and is ignored.
  always_comb begin
    w_eoi = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_wr && address == 3'd4 && writedata[3:0] == 4'(i)) begin
        w_eoi[i] = 1'b1;
      end else begin
        w_eoi[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rd = 16'd0;
    case (address)
      3'd0:    w_rd = 16'(w_sync);
      3'd1:    w_rd = 16'(r_pending);
      3'd2:    w_rd = 16'(r_enable);
      3'd3:    w_rd = 16'(r_edge);
      3'd4:    w_rd = {w_active[4], 11'd0, w_active[3:0]};
      default: w_rd = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_sync_d <= w_sync;
    end
  end

  // Set has priority over clear so an event arriving with its own acknowledge is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_enable   <= '0;
      r_edge     <= '0;
      r_readdata <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr && address == 3'd2) begin
        r_enable <= w_wdata;
      end else begin
        r_enable <= r_enable;
      end
      if (w_wr && address == 3'd3) begin
        r_edge <= w_wdata;
      end else begin
        r_edge <= r_edge;
      end
      r_readdata <= w_rd;
      r_irq      <= |(r_pending & r_enable);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: a register-access vector table plus hand-written
// sequences for capture latency, level re-pend, priority, set/clear races and async reset.
module tb_irq_aggregator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [0:21];

  irq_aggregator #(.N_SRC(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {15'd0, irq}, {15'd0, exp});
  endtask

  // Called on a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [15:0] d;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d readdata", i), d, vecs[i].exp_rd);
      check_irq($sformatf("vec%0d irq", i), vecs[i].exp_irq);
    end
  endtask

  initial begin
    logic [15:0] d;

    for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 3'd0, 16'h0000, 3'(i), 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 16'hFFFF, 3'd2, 16'h00FF, 1'b0};
    vecs[9]  = '{1'b1, 3'd2, 16'h0000, 3'd2, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 16'hABCD, 3'd3, 16'h00CD, 1'b0};
    vecs[11] = '{1'b1, 3'd3, 16'h0000, 3'd3, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 3'd6, 16'hFFFF, 3'd6, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 3'd5, 16'h0080, 3'd1, 16'h0080, 1'b0};
    vecs[15] = '{1'b1, 3'd4, 16'h0007, 3'd1, 16'h0000, 1'b0};
    vecs[16] = '{1'b1, 3'd5, 16'h0100, 3'd1, 16'h0000, 1'b0};
    vecs[17] = '{1'b1, 3'd5, 16'h0040, 3'd5, 16'h0000, 1'b0};
    vecs[18] = '{1'b1, 3'd4, 16'h0008, 3'd1, 16'h0040, 1'b0};
    vecs[19] = '{1'b1, 3'd2, 16'h0040, 3'd4, 16'h8006, 1'b1};
    vecs[20] = '{1'b1, 3'd1, 16'h0040, 3'd1, 16'h0000, 1'b0};
    vecs[21] = '{1'b1, 3'd2, 16'h0000, 3'd2, 16'h0000, 1'b0};

    reset_n    = 1'b0;
    irq_src    = 8'h00;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_vecs(0, 7);

    // Level source with ENABLE=0: pending latches, irq stays low.
    irq_src = 8'h01;
    repeat (4) @(negedge clk);
    check_irq("masked level irq", 1'b0);
    rd(3'd1, d); check("masked level pending", d, 16'h0001);
    rd(3'd0, d); check("raw level", d, 16'h0001);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    wr(3'd1, 16'h0001);
    rd(3'd1, d); check("masked level cleared", d, 16'h0000);

    // One-cycle pulse in edge mode: irq at k+3.
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'h0001);
    irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    @(negedge clk);
    @(negedge clk); check_irq("edge irq k+2", 1'b0);
    @(negedge clk); check_irq("edge irq k+3", 1'b1);
    rd(3'd1, d); check("edge pending", d, 16'h0001);
    rd(3'd4, d); check("edge active", d, 16'h8000);
    wr(3'd4, 16'h0000);
    check_irq("eoi irq same edge", 1'b1);
    @(negedge clk); check_irq("eoi irq next edge", 1'b0);
    rd(3'd1, d); check("eoi pending", d, 16'h0000);
    wr(3'd3, 16'h0000);
    wr(3'd2, 16'h0000);

    // Level source 3 held high re-pends after W1C.
    wr(3'd2, 16'h0008);
    irq_src = 8'h08;
    repeat (4) @(negedge clk);
    check_irq("level irq", 1'b1);
    wr(3'd1, 16'h0008);
    check_irq("level w1c irq", 1'b1);
    rd(3'd1, d); check("level re-pend", d, 16'h0008);
    check_irq("level irq held", 1'b1);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    wr(3'd1, 16'h0008);
    check_irq("level drop irq same edge", 1'b1);
    rd(3'd1, d); check("level drop pending", d, 16'h0000);
    check_irq("level drop irq fall", 1'b0);
    wr(3'd2, 16'h0000);

    // Priority between sources 2 and 5.
    wr(3'd5, 16'h0024);
    wr(3'd2, 16'h0024);
    rd(3'd4, d); check("prio active 2", d, 16'h8002);
    wr(3'd4, 16'h0002);
    rd(3'd4, d); check("prio active 5", d, 16'h8005);
    wr(3'd4, 16'h0005);
    rd(3'd4, d); check("prio active none", d, 16'h0000);
    check_irq("prio irq off", 1'b0);
    wr(3'd2, 16'h0000);

    // Rising edge on source 1 captured on the same edge as a W1C of bit 1.
    wr(3'd3, 16'h0002);
    irq_src = 8'h02;
    @(negedge clk);
    @(negedge clk);
    wr(3'd1, 16'h0002);
    irq_src = 8'h00;
    rd(3'd1, d); check("set beats clear", d, 16'h0002);
    repeat (2) @(negedge clk);
    wr(3'd1, 16'h0002);
    rd(3'd1, d); check("edge w1c clears", d, 16'h0000);
    wr(3'd3, 16'h0000);

    run_vecs(8, 21);

    // Asynchronous reset while irq is high.
    wr(3'd2, 16'h0001);
    wr(3'd5, 16'h0001);
    address = 3'd1;
    @(negedge clk);
    check("pre-reset readdata", readdata, 16'h0001);
    check_irq("pre-reset irq", 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_irq("async reset irq", 1'b0);
    check("async reset readdata", readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    run_vecs(0, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
